// File: rtl/lamp_mon_pkg.sv
// Shared types and fault codes for the lamp conflict monitor.
package lamp_mon_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLASH = 1'b1
   } state_t;

   localparam logic [2:0] F_NONE      = 3'd0;
   localparam logic [2:0] F_CONFLICT  = 3'd1;
   localparam logic [2:0] F_MULTI     = 3'd2;
   localparam logic [2:0] F_DARK      = 3'd3;
   localparam logic [2:0] F_SHORT_YLW = 3'd4;
   localparam logic [2:0] F_SKIP_YLW  = 3'd5;

   // Lowest code wins when several checks fire together.
   function automatic logic [2:0] fault_code(input logic conflict,
                                             input logic multi,
                                             input logic dark,
                                             input logic short_ylw,
                                             input logic skip_ylw);
      logic [2:0] code;
      code = F_NONE;
      if (conflict)       code = F_CONFLICT;
      else if (multi)     code = F_MULTI;
      else if (dark)      code = F_DARK;
      else if (short_ylw) code = F_SHORT_YLW;
      else if (skip_ylw)  code = F_SKIP_YLW;
      return code;
   endfunction

endpackage

// File: rtl/lamp_conflict_monitor_dir_check.sv
// Per-direction lamp checks: multiple lamps, dark timeout, short yellow, skipped yellow.
module lamp_dir_check
   import lamp_mon_pkg::*;
#(
   parameter int MIN_YLW  = 3,
   parameter int MAX_DARK = 4
) (
   input  logic CK,
   input  logic CLRN,
   input  logic clear,
   input  logic r_g,
   input  logic r_y,
   input  logic r_r,
   input  logic p_g,
   input  logic p_y,
   output logic multi,
   output logic dark,
   output logic short_ylw,
   output logic skip_ylw
);

   localparam int DW = $clog2(MAX_DARK + 1);
   localparam int YW = $clog2(MIN_YLW + 1);
   localparam logic [DW-1:0] DARK_MAX = DW'(MAX_DARK);
   localparam logic [YW-1:0] YLW_MAX  = YW'(MIN_YLW);

   logic [DW-1:0] dcnt;
   logic [YW-1:0] ycnt;

   always_ff @(posedge CK) begin
      if (!CLRN) begin
         dcnt <= '0;
      end else if (clear || r_g || r_y || r_r) begin
         dcnt <= '0;
      end else if (dcnt != DARK_MAX) begin
         dcnt <= dcnt + 1'b1;
      end
   end

   // ycnt equals the length of the current yellow run as seen through p_y.
   always_ff @(posedge CK) begin
      if (!CLRN) begin
         ycnt <= '0;
      end else if (clear || !r_y) begin
         ycnt <= '0;
      end else if (ycnt != YLW_MAX) begin
         ycnt <= ycnt + 1'b1;
      end
   end

   assign multi     = (r_g & r_y) | (r_g & r_r) | (r_y & r_r);
   assign dark      = (dcnt == DARK_MAX);
   assign short_ylw = p_y & ~r_y & (ycnt < YLW_MAX);
   assign skip_ylw  = p_g & ~r_g & r_r;

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Safety stage between the traffic-light controller and the lamp drivers.
// state | meaning
// RUN   | lamps follow the registered requests, checks active
// FLASH | fault latched, both reds flash until FLT_ACK
module lamp_conflict_monitor
   import lamp_mon_pkg::*;
#(
   parameter int MIN_YLW   = 3,
   parameter int MAX_DARK  = 4,
   parameter int FLASH_DIV = 8
) (
   input  logic       CK,
   input  logic       CLRN,
   input  logic       GRN1,
   input  logic       YLW1,
   input  logic       RED1,
   input  logic       GRN2,
   input  logic       YLW2,
   input  logic       RED2,
   input  logic       FLT_ACK,
   output logic       LGRN1,
   output logic       LYLW1,
   output logic       LRED1,
   output logic       LGRN2,
   output logic       LYLW2,
   output logic       LRED2,
   output logic       FAULT,
   output logic [2:0] FCODE
);

   localparam int FW = $clog2(FLASH_DIV + 1);
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

   state_t        state, state_nx;
   logic          rg1, ry1, rr1, rg2, ry2, rr2;
   logic          pg1, py1, pg2, py2;
   logic [FW-1:0] fcnt;
   logic          phase;
   logic          clear, ack_exit, conflict;
   logic          multi1, dark1, short1, skip1;
   logic          multi2, dark2, short2, skip2;
   logic [2:0]    code;

   assign clear    = (state == FLASH);
   assign ack_exit = (state == FLASH) && FLT_ACK;

   // On exit the previous copy is loaded with the same value as the live copy,
   // so transition checks see no edge in the first RUN cycle.
   always_ff @(posedge CK) begin
      if (!CLRN) begin
         {rg1, ry1, rr1, rg2, ry2, rr2} <= '0;
         {pg1, py1, pg2, py2}           <= '0;
      end else begin
         {rg1, ry1, rr1, rg2, ry2, rr2} <= {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
         if (ack_exit) {pg1, py1, pg2, py2} <= {GRN1, YLW1, GRN2, YLW2};
         else          {pg1, py1, pg2, py2} <= {rg1, ry1, rg2, ry2};
      end
   end

   lamp_dir_check #(.MIN_YLW(MIN_YLW), .MAX_DARK(MAX_DARK)) u_dir1 (
      .CK(CK), .CLRN(CLRN), .clear(clear),
      .r_g(rg1), .r_y(ry1), .r_r(rr1), .p_g(pg1), .p_y(py1),
      .multi(multi1), .dark(dark1), .short_ylw(short1), .skip_ylw(skip1)
   );

   lamp_dir_check #(.MIN_YLW(MIN_YLW), .MAX_DARK(MAX_DARK)) u_dir2 (
      .CK(CK), .CLRN(CLRN), .clear(clear),
      .r_g(rg2), .r_y(ry2), .r_r(rr2), .p_g(pg2), .p_y(py2),
      .multi(multi2), .dark(dark2), .short_ylw(short2), .skip_ylw(skip2)
   );

   assign conflict = (rg1 | ry1) & (rg2 | ry2);
   assign code     = fault_code(conflict, multi1 | multi2, dark1 | dark2,
                                short1 | short2, skip1 | skip2);

   always_ff @(posedge CK) begin
      if (!CLRN) state <= RUN;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (code != F_NONE) state_nx = FLASH;
         FLASH:   if (FLT_ACK)        state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   // FCODE only ever loads a non-zero code on the RUN->FLASH edge.
   always_ff @(posedge CK) begin
      if (!CLRN)                FCODE <= F_NONE;
      else if (state == RUN)    FCODE <= code;
      else if (FLT_ACK)         FCODE <= F_NONE;
   end

   always_ff @(posedge CK) begin
      if (!CLRN || state == RUN) begin
         fcnt  <= '0;
         phase <= 1'b1;
      end else if (fcnt == FLASH_LAST) begin
         fcnt  <= '0;
         phase <= ~phase;
      end else begin
         fcnt  <= fcnt + 1'b1;
      end
   end

   always_comb begin
      {LGRN1, LYLW1, LRED1, LGRN2, LYLW2, LRED2} = {rg1, ry1, rr1, rg2, ry2, rr2};
      FAULT = 1'b0;
      if (state == FLASH) begin
         {LGRN1, LYLW1, LRED1, LGRN2, LYLW2, LRED2} = {2'b00, phase, 2'b00, phase};
         FAULT = 1'b1;
      end
   end

endmodule
